demux4_stream: RTL and testbench

DEMUX4_STREAM -- requirements
Module: demux4_stream

---
 rtl/demux4_stream.sv | 54 +++++
 tb/tb_demux4_stream.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/demux4_stream.sv
// demux4_stream: 1-to-4 stream demux with registered per-channel outputs; optional per-channel transfer counters under DEMUX4_STATS_EN
module demux4_stream #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
`ifdef DEMUX4_STATS_EN
  input  logic [1:0]       cnt_sel,
  input  logic             cnt_clr,
  output logic [7:0]       cnt_out,
`endif
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_dest,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready
);
  logic [WIDTH-1:0] data [4];
  logic [3:0]       wr;
  assign in_ready  = !out_valid[in_dest] || out_ready[in_dest];
  assign out_data0 = data[0];
  assign out_data1 = data[1];
  assign out_data2 = data[2];
  assign out_data3 = data[3];
  // one-hot write strobe for the addressed channel on an accepted word
  always_comb wr = (in_valid && in_ready) ? 4'b0001 << in_dest : 4'b0000;
  // channel registers: a write refills, a drain without refill empties, a stall holds
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= '0;
      for (int k = 0; k < 4; k++) data[k] <= '0;
    end else begin
      out_valid <= wr | (out_valid & ~out_ready);
      for (int k = 0; k < 4; k++) if (wr[k]) data[k] <= in_data;
    end
  end
`ifdef DEMUX4_STATS_EN
  logic [7:0] cnt [4];
  assign cnt_out = cnt[cnt_sel];
  // per-channel output transfer counters, clear wins over increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset || cnt_clr) begin
      for (int k = 0; k < 4; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) if (out_valid[k] && out_ready[k]) cnt[k] <= cnt[k] + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_demux4_stream.sv
// tb_demux4_stream: directed self-checking bench for demux4_stream
module tb_demux4_stream;
  logic        clk = 0;
  logic        reset = 1;
  logic [15:0] in_data = '0;
  logic [1:0]  in_dest = '0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [15:0] out_data0, out_data1, out_data2, out_data3;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = '0;
  int checks = 0;
  int errors = 0;
`ifdef DEMUX4_STATS_EN
  logic [1:0] cnt_sel = '0;
  logic       cnt_clr = 0;
  logic [7:0] cnt_out;
`endif
  demux4_stream #(.WIDTH(16)) dut (
    .clk(clk),
    .reset(reset),
`ifdef DEMUX4_STATS_EN
    .cnt_sel(cnt_sel),
    .cnt_clr(cnt_clr),
    .cnt_out(cnt_out),
`endif
    .in_data(in_data),
    .in_dest(in_dest),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data0(out_data0),
    .out_data1(out_data1),
    .out_data2(out_data2),
    .out_data3(out_data3),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    reset = 1;
    #2;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid got %b want 0000", out_valid); end
    checks++; if ({out_data0, out_data1, out_data2, out_data3} !== 64'h0) begin errors++; $display("FAIL reset_data got %h want 0", {out_data0, out_data1, out_data2, out_data3}); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    reset = 0;
  endtask
  task automatic test_route();
    @(negedge clk);
    in_dest = 2; in_data = 16'hA5A5; in_valid = 1; out_ready = 4'b0000;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL route_ready_empty got %b want 1", in_ready); end
    edge1();
    checks++; if (out_valid !== 4'b0100) begin errors++; $display("FAIL route_valid got %b want 0100", out_valid); end
    checks++; if (out_data2 !== 16'hA5A5) begin errors++; $display("FAIL route_data2 got %h want a5a5", out_data2); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL route_ready_full got %b want 0", in_ready); end
  endtask
  task automatic test_stall();
    @(negedge clk);
    in_dest = 1; in_data = 16'h1234; in_valid = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_ch1 got %b want 1", in_ready); end
    edge1();
    checks++; if (out_valid !== 4'b0110) begin errors++; $display("FAIL stall_valid got %b want 0110", out_valid); end
    checks++; if (out_data1 !== 16'h1234) begin errors++; $display("FAIL stall_data1 got %h want 1234", out_data1); end
    checks++; if (out_data2 !== 16'hA5A5) begin errors++; $display("FAIL stall_data2 got %h want a5a5", out_data2); end
    @(negedge clk);
    in_dest = 2; in_data = 16'hFFFF; in_valid = 1;
    edge1();
    checks++; if (out_data2 !== 16'hA5A5) begin errors++; $display("FAIL stall_no_overwrite got %h want a5a5", out_data2); end
    checks++; if (out_valid !== 4'b0110) begin errors++; $display("FAIL stall_hold_valid got %b want 0110", out_valid); end
  endtask
  task automatic test_drain();
    @(negedge clk);
    in_valid = 0; out_ready = 4'b0110;
    edge1();
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL drain_valid got %b want 0000", out_valid); end
    checks++; if (out_data1 !== 16'h1234 || out_data2 !== 16'hA5A5) begin errors++; $display("FAIL drain_retain got %h/%h want 1234/a5a5", out_data1, out_data2); end
  endtask
  task automatic test_back_to_back();
    @(negedge clk);
    out_ready = 4'b1111; in_dest = 0; in_valid = 1;
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) @(negedge clk);
      in_data = 16'(i);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b want 1", i, in_ready); end
      edge1();
      checks++; if (out_data0 !== 16'(i) || out_valid[0] !== 1'b1) begin errors++; $display("FAIL b2b_data[%0d] got %h v=%b want %h v=1", i, out_data0, out_valid[0], 16'(i)); end
    end
    @(negedge clk);
    in_valid = 0;
    edge1();
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL b2b_empty got %b want 0000", out_valid); end
  endtask
  task automatic test_reset_midcycle();
    @(negedge clk);
    out_ready = 4'b0000; in_valid = 1; in_dest = 0; in_data = 16'h0011;
    @(negedge clk);
    in_dest = 1; in_data = 16'h0022;
    @(negedge clk);
    in_dest = 3; in_data = 16'h0033;
    edge1();
    in_valid = 0;
    checks++; if (out_valid !== 4'b1011) begin errors++; $display("FAIL mid_fill got %b want 1011", out_valid); end
    #2;
    reset = 1;
    #1;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL mid_reset_valid got %b want 0000", out_valid); end
    checks++; if ({out_data0, out_data1, out_data2, out_data3} !== 64'h0) begin errors++; $display("FAIL mid_reset_data got %h want 0", {out_data0, out_data1, out_data2, out_data3}); end
    @(negedge clk);
    reset = 0; in_valid = 1; in_dest = 3; in_data = 16'h0077;
    edge1();
    in_valid = 0;
    checks++; if (out_valid !== 4'b1000) begin errors++; $display("FAIL post_reset_valid got %b want 1000", out_valid); end
    checks++; if (out_data3 !== 16'h0077 || out_data0 !== 16'h0 || out_data1 !== 16'h0) begin errors++; $display("FAIL post_reset_data got %h/%h/%h want 0077/0000/0000", out_data3, out_data0, out_data1); end
  endtask
`ifdef DEMUX4_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    reset = 1;
    #1;
    reset = 0;
    cnt_sel = 3; out_ready = 4'b1000; in_dest = 3; in_valid = 1;
    for (int i = 0; i < 258; i++) begin
      in_data = 16'(i);
      edge1();
      @(negedge clk);
    end
    in_valid = 0;
    #1;
    checks++; if (cnt_out !== 8'd1) begin errors++; $display("FAIL stats_wrap got %0d want 1", cnt_out); end
    cnt_sel = 0;
    #1;
    checks++; if (cnt_out !== 8'd0) begin errors++; $display("FAIL stats_ch0 got %0d want 0", cnt_out); end
    cnt_sel = 3; cnt_clr = 1;
    edge1();
    cnt_clr = 0;
    checks++; if (cnt_out !== 8'd0) begin errors++; $display("FAIL stats_clr got %0d want 0", cnt_out); end
  endtask
`endif
  initial begin
    test_reset();
    test_route();
    test_stall();
    test_drain();
    test_back_to_back();
    test_reset_midcycle();
`ifdef DEMUX4_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end
endmodule
